// File: rtl/ext_out_uart_pkg.sv
// rtl/ext_out_uart_pkg.sv - shared types and defaults for the ext_out UART transmitter
package ext_out_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 8;

endpackage

// File: rtl/ext_out_uart_tx_byte_fifo.sv
// rtl/ext_out_uart_tx_byte_fifo.sv - synchronous byte FIFO, show-ahead head output
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot first, so a push into a full FIFO is accepted alongside it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/ext_out_uart_tx.sv
// rtl/ext_out_uart_tx.sv - captures changes on the CPU output port and sends them as 8N1 frames
module ext_out_uart_tx
    import ext_out_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int DATA_W       = UART_DATA_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             ext_out,
    input  logic                          en,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          overflow
);
    localparam int BW   = $clog2(CLKS_PER_BIT);
    localparam int BITW = $clog2(UART_DATA_BITS);

    tx_state_t         state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [BITW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              tx_q, tx_d;
    logic [DATA_W-1:0] last_val_q, last_val_d;
    logic              overflow_q, overflow_d;

    logic              capture, fifo_pop, fifo_full, fifo_empty, baud_last;
    logic [DATA_W-1:0] fifo_dout;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (capture),
        .pop_i   (fifo_pop),
        .din_i   (ext_out),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // last_val tracks every captured value, even a dropped one, so a held value never re-fires.
    assign capture    = en && (ext_out != last_val_q);
    assign last_val_d = capture ? ext_out : last_val_q;
    assign overflow_d = overflow_q | (capture && fifo_full && !fifo_pop);
    assign baud_last  = (baud_q == BW'(CLKS_PER_BIT - 1));

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign overflow = overflow_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_dout;
                    bit_d    = '0;
                    baud_d   = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = sh_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BITW'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {1'b0, sh_q[DATA_W-1:1]};
                        tx_d  = sh_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            tx_q       <= 1'b1;
            last_val_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
            last_val_q <= last_val_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_ext_out_uart_tx.sv
// tb/tb_ext_out_uart_tx.sv - self-checking bench for ext_out_uart_tx
module tb_ext_out_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [7:0]    ext_out = 8'h00;
    logic          tx, busy, overflow;
    logic [CW-1:0] fifo_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    ext_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ext_out  (ext_out),
        .en       (en),
        .tx       (tx),
        .busy     (busy),
        .fifo_cnt (fifo_cnt),
        .overflow (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a byte queue plus a frame timer that walks the 10-bit 8N1 pattern.
    logic [7:0] mq[$];
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_cur = 8'h00;
    bit         m_ovf = 0;
    bit         m_active = 0;
    bit         m_popping;
    int         m_t = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_last = 8'h00;
            m_ovf = 0;
            m_active = 0;
            m_t = 0;
        end else begin
            m_popping = !m_active && (mq.size() > 0);
            if (m_active) begin
                m_t++;
                if (m_t == 10 * CPB) m_active = 0;
            end else if (m_popping) begin
                m_cur = mq.pop_front();
                m_active = 1;
                m_t = 0;
            end
            if (en && ext_out != m_last) begin
                if (mq.size() < DEPTH) mq.push_back(ext_out);
                else m_ovf = 1;
                m_last = ext_out;
            end
        end
    end

    function automatic logic m_tx_exp();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_t / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tx", tx, m_tx_exp());
            chk("busy", busy, (m_active || mq.size() != 0));
            chk("fifo_cnt", fifo_cnt, mq.size());
            chk("overflow", overflow, m_ovf);
        end
    end

    // UART receiver: samples mid-bit and collects whole 10-bit frames (bit i = i-th bit on the line).
    logic [9:0] rx_q[$];
    logic [9:0] rx_bits = '1;
    bit         rx_busy = 0;
    int         rx_n = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_busy = 0;
        end else begin
            if (!rx_busy && tx === 1'b0) begin
                rx_busy = 1;
                rx_n = 0;
            end
            if (rx_busy) begin
                if (rx_n % CPB == CPB / 2) rx_bits[rx_n / CPB] = tx;
                if (rx_n == 9 * CPB + CPB / 2) begin
                    rx_q.push_back(rx_bits);
                    rx_busy = 0;
                end
                rx_n++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        ext_out = 8'h00;
        step(2);
        rx_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, rx_q.size(), n);
    endtask

    function automatic logic [9:0] frame_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 10'h3ff;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] f;
        do_reset();
        cmp_en = 1;
        chk("reset_tx", tx, 1);
        chk("reset_cnt", fifo_cnt, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", overflow, 0);

        // 0x0F: one push, tx falls one cycle after the push edge
        en = 1'b1;
        ext_out = 8'h0F;
        step(1);
        chk("t1_cnt_after_push", fifo_cnt, 1);
        chk("t1_tx_idle_on_push", tx, 1);
        step(1);
        chk("t1_tx_fall", tx, 0);
        chk("t1_cnt_popped", fifo_cnt, 0);
        wait_frames(1, 80, "t1_frames");
        chk("t1_frame_bits", frame_at(0), 10'b1000011110);
        step(50);
        chk("t1_single_frame", rx_q.size(), 1);
        chk("t1_busy_done", busy, 0);

        // 0xA5 frame and decode
        do_reset();
        en = 1'b1;
        ext_out = 8'hA5;
        wait_frames(1, 80, "t2_frames");
        f = frame_at(0);
        chk("t2_frame_bits", f, 10'b1101001010);
        chk("t2_decode", f[8:1], 8'hA5);

        // en low ignores toggles, raising it sends exactly one frame
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ext_out = (i % 2 == 0) ? 8'h11 : 8'h22;
            step(1);
            chk("t3_cnt_gated", fifo_cnt, 0);
            chk("t3_tx_gated", tx, 1);
        end
        ext_out = 8'h22;
        en = 1'b1;
        wait_frames(1, 80, "t3_frames");
        step(60);
        chk("t3_single_frame", rx_q.size(), 1);
        chk("t3_data", frame_at(0) >> 1 & 10'hff, 8'h22);

        // ten values on ten edges: fill, drop the tenth, drain nine in order
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ext_out = 8'h31 + 8'(i);
            step(1);
            if (i == 8) chk("t4_full_after_edge9", fifo_cnt, 8);
        end
        chk("t4_overflow", overflow, 1);
        chk("t4_cnt_still_full", fifo_cnt, 8);
        wait_frames(9, 500, "t4_frames");
        step(60);
        chk("t4_frame_count", rx_q.size(), 9);
        for (int i = 0; i < 9; i++) chk("t4_data", frame_at(i) >> 1 & 10'hff, 8'h31 + i);
        chk("t4_overflow_sticky", overflow, 1);

        // async reset mid-DATA with three bytes queued
        for (int i = 0; i < 4; i++) begin
            ext_out = 8'h41 + 8'(i);
            step(1);
        end
        chk("t5_queued", fifo_cnt, 3);
        step(10);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_tx", tx, 1);
        chk("t5_async_cnt", fifo_cnt, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_ovf", overflow, 0);
        @(negedge clk);
        ext_out = 8'h00;
        step(2);
        rx_q.delete();
        rst = 1'b0;
        step(60);
        chk("t5_no_frame", rx_q.size(), 0);
        chk("t5_cnt_zero", fifo_cnt, 0);
        ext_out = 8'h55;
        wait_frames(1, 80, "t5_frames");
        chk("t5_data", frame_at(0) >> 1 & 10'hff, 8'h55);

        // push on the exact edge the FSM pops from a full FIFO
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ext_out = 8'h61 + 8'(i);
            step(1);
        end
        step(33);
        chk("t6_full_before", fifo_cnt, 8);
        ext_out = 8'h6A;
        step(1);
        chk("t6_cnt_kept", fifo_cnt, 8);
        chk("t6_no_overflow", overflow, 0);
        wait_frames(10, 600, "t6_frames");
        for (int i = 0; i < 10; i++) chk("t6_data", frame_at(i) >> 1 & 10'hff, 8'h61 + i);
        chk("t6_ovf_final", overflow, 0);

        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
